// File: rtl/regfile_pkg.sv
// Shared constants and slice helpers for the register-file writeback path.
// Packed requester buses place requester i at bits [i*width +: width].
package regfile_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int NREGS   = 32;

  localparam logic [RADDR_W-1:0] ZERO_REG = 5'd0;

  localparam int ADDR_STRIDE = RADDR_W;
  localparam int DATA_STRIDE = XLEN;

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter for the shared writeback port.
// Grant depends only on req_valid and the rotating priority pointer.
module wb_rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic             transfer,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;
  int               cand;

  // Scan upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(rr_ptr_q) + off) % NREQ;
      if (!found && req_valid[IDX_W'(cand)]) begin
        found                 = 1'b1;
        grant[IDX_W'(cand)]   = 1'b1;
        grant_idx             = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      rr_ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file: round-robin port sharing,
// registered write outputs and a pending-write scoreboard for RAW stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int RADDR_W = regfile_pkg::RADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*RADDR_W-1:0] req_addr,
  input  logic [NREQ*XLEN-1:0]    req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    alloc_valid,
  input  logic [RADDR_W-1:0]      alloc_addr,
  input  logic                    flush,
  input  logic [RADDR_W-1:0]      rs1_addr,
  input  logic [RADDR_W-1:0]      rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    write_reg,
  output logic [RADDR_W-1:0]      dstreg_addr,
  output logic [XLEN-1:0]         dstreg_data
);

  localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NUM_REGS = 1 << RADDR_W;
  localparam logic [RADDR_W-1:0] ZERO_ADDR = RADDR_W'(ZERO_REG);

  logic [NREQ-1:0]     grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                transfer;
  logic [RADDR_W-1:0]  gnt_addr;
  logic [XLEN-1:0]     gnt_data;

  logic                write_reg_q, write_reg_d;
  logic [RADDR_W-1:0]  dstreg_addr_q, dstreg_addr_d;
  logic [XLEN-1:0]     dstreg_data_q, dstreg_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  wb_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .transfer  (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |grant;
  assign gnt_addr  = req_addr[slice_lsb(int'(grant_idx), RADDR_W) +: RADDR_W];
  assign gnt_data  = req_data[slice_lsb(int'(grant_idx), XLEN) +: XLEN];

  // A write to register 0 still retires its producer but never reaches the file.
  always_comb begin
    write_reg_d   = transfer && (gnt_addr != ZERO_ADDR);
    dstreg_addr_d = dstreg_addr_q;
    dstreg_data_d = dstreg_data_q;
    if (transfer) begin
      dstreg_addr_d = gnt_addr;
      dstreg_data_d = gnt_data;
    end
  end

  // Flush beats a new allocation, which beats the retiring write's clear.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (alloc_valid && (alloc_addr == RADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if (transfer && (gnt_addr == RADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg_q   <= 1'b0;
      dstreg_addr_q <= '0;
      dstreg_data_q <= '0;
      busy_q        <= '0;
    end else begin
      write_reg_q   <= write_reg_d;
      dstreg_addr_q <= dstreg_addr_d;
      dstreg_data_q <= dstreg_data_d;
      busy_q        <= busy_d;
    end
  end

  assign write_reg   = write_reg_q;
  assign dstreg_addr = dstreg_addr_q;
  assign dstreg_data = dstreg_data_q;
  assign rs1_busy    = (rs1_addr != ZERO_ADDR) && busy_q[rs1_addr];
  assign rs2_busy    = (rs2_addr != ZERO_ADDR) && busy_q[rs2_addr];

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback requesters (ALU, load unit, mul/div) using round-robin arbitration and a valid/ready handshake.
- Keeps a pending-write scoreboard (busy bit per architectural register) so the decode stage can stall on RAW hazards.
- Sits between the execute/memory units and the register file write port (write_reg, dstreg_addr, dstreg_data).

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- XLEN, 32, register data width.
- RADDR_W, 5, register address width (32 registers; register 0 hardwired zero).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester writeback valid.
- req_addr  in  NREQ*RADDR_W  packed destination addresses; requester i occupies bits [i*RADDR_W +: RADDR_W].
- req_data  in  NREQ*XLEN  packed write data; requester i occupies bits [i*XLEN +: XLEN].
- req_ready  out  NREQ  one-hot (or zero) grant, combinational.
- alloc_valid  in  1  decode issues an instruction that will write alloc_addr.
- alloc_addr  in  RADDR_W  destination register being allocated.
- flush  in  1  pipeline flush; clears the scoreboard.
- rs1_addr  in  RADDR_W  decode source 1 address for the hazard query.
- rs2_addr  in  RADDR_W  decode source 2 address for the hazard query.
- rs1_busy  out  1  rs1 has a pending write, combinational.
- rs2_busy  out  1  rs2 has a pending write, combinational.
- write_reg  out  1  to regfile: write enable, registered.
- dstreg_addr  out  RADDR_W  to regfile: write address, registered.
- dstreg_data  out  XLEN  to regfile: write data, registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write_reg=0, dstreg_addr=0, dstreg_data=0.
  - rr_ptr=0, busy=0.
  - These values hold while rst_n is low. Reset mid-transfer discards any in-flight write.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, upward with wrap modulo NREQ.
  - The first valid index is granted and its req_ready bit is asserted.
  - No valid requests gives req_ready=0.
  - req_ready never depends on anything except req_valid and rr_ptr. The port always accepts one write per cycle, so there are no stall cycles.
- Handshake:
  - A transfer occurs on a clock edge where req_valid[i] and req_ready[i] are both high.
  - A requester holds its valid/addr/data until the transfer.
  - A requester may deassert valid without a transfer.
- rr_ptr update:
  - On a transfer from index g, rr_ptr = (g+1) mod NREQ.
  - Otherwise rr_ptr is unchanged.
  - Wrap case: grant at index NREQ-1 sets rr_ptr=0.
- Output register (latency 1):
  - At a transfer edge, dstreg_addr/dstreg_data take the granted addr/data.
  - write_reg = (granted addr != 0).
  - With no transfer, write_reg=0 and dstreg_addr/dstreg_data hold their last values.
  - Back-to-back transfers give a write every cycle.
- Register-0 writes: the handshake completes normally (producer freed), but write_reg stays 0.
- Scoreboard update at each edge, for each register r:
  - set_r = alloc_valid & (alloc_addr==r) & (r!=0) & !flush.
  - clr_r = transfer & (granted addr==r).
  - busy[r] next = flush ? 0 : set_r ? 1 : clr_r ? 0 : busy[r].
- Scoreboard precedence:
  - Simultaneous alloc and clear of the same register: the set wins (the new producer is outstanding).
  - flush beats alloc.
  - flush does not suppress a same-cycle transfer into the output register.
- Hazard query:
  - rs1_busy = busy[rs1_addr]; rs2_busy = busy[rs2_addr].
  - Address 0 always reads not busy.
  - busy[r] clears on the same edge the write is registered. In the next cycle the regfile's same-cycle write bypass supplies the new value, so decode can proceed without an extra bubble.
- The block is not required to track multiple outstanding writes to the same register; the decode stage must not issue a second writer while busy.

Decomposition:
- Shared package regfile_pkg:
  - XLEN=32, RADDR_W=5, NREGS=32, ZERO_REG=5'd0.
  - Packed-port slice helper constants.
- One sub-module, wb_rr_arbiter:
  - Parameter NREQ; inputs req_valid and a transfer strobe; outputs one-hot grant and grant index.
  - Owns rr_ptr with the same asynchronous active-low reset.
- The top level holds the output register and the scoreboard.

Test Plan:
- Reset: assert rst_n=0 mid-stream with req_valid=3'b111 -> write_reg=0, dstreg_addr=0, dstreg_data=0 immediately; after release, first grant goes to requester 0.
- Round-robin fairness: hold req_valid=3'b111 with addrs 1/2/3 and data 0xA/0xB/0xC -> grants 0,1,2,0,... on consecutive cycles; regfile writes (1,0xA),(2,0xB),(3,0xC) one cycle after each grant.
- Wrap/skip: rr_ptr=2, req_valid=3'b011 -> requester 0 granted, rr_ptr becomes 1; then only req_valid[2] high -> requester 2 granted, rr_ptr becomes 0.
- Register-0 write: requester 1 writes addr 0, data 0xDEADBEEF -> req_ready[1]=1, write_reg stays 0, no busy change.
- Scoreboard: alloc addr 5 -> rs1_addr=5 reads busy next cycle; requester 2 writes addr 5 -> busy clears on that edge, with write_reg=1, dstreg_addr=5 in the same cycle. Alloc 5 in the same cycle as the clear of 5 -> busy stays 1.
- Flush: busy on regs 3 and 7, then flush=1 with alloc_valid=1 to addr 9 -> all busy=0 including 9; a concurrent transfer to reg 3 still produces write_reg=1, dstreg_addr=3.
